// File: rtl/dmux_rr_scheduler_pkg.sv
// Shared definitions for the round-robin selector scheduler.
// Default sizes and FSM state encoding.
package dmux_sched_pkg;

  localparam int N_DEF     = 8;
  localparam int SEL_W_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/dmux_rr_scheduler_rr_pick.sv
// Rotating priority encoder: first set request at or after start,
// wrapping modulo N.
module rr_pick
  import dmux_sched_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] pos;

  // Scan from the far end so the nearest hit is written last.
  always_comb begin
    any = 1'b0;
    idx = start;
    pos = start;
    for (int i = N - 1; i >= 0; i--) begin
      pos = start + SEL_W'(i);
      if (req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/dmux_rr_scheduler.sv
// Round-robin owner of the 8:1 selector sel input with
// per-grant hold quota and forced-release pulse.
module dmux_rr_scheduler
  import dmux_sched_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  sched_state_e state, state_nxt;

  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] sel_nxt, start, idx;
  logic [N-1:0]     req_eff, gnt_nxt;
  logic [HW-1:0]    hold, hold_nxt;
  logic             any, hit_max, rel;
  logic             valid_nxt, pre_nxt;

  assign hit_max = (hold == HW'(MAX_HOLD - 1));
  assign rel = (state == GRANT)
             && (done || !req[sel] || hit_max);

  // Same encoder serves idle arbitration and release handoff.
  assign start = (state == GRANT) ? sel + SEL_W'(1) : ptr;
  assign req_eff = (state == GRANT && done)
                 ? req & ~(N'(1) << sel) : req;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (req_eff),
    .start (start),
    .any   (any),
    .idx   (idx)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (en && any) state_nxt = GRANT;
      GRANT: if (rel && !(en && any)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_nxt   = sel;
    valid_nxt = gnt_valid;
    hold_nxt  = hold;
    ptr_nxt   = ptr;
    pre_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && any) begin
          sel_nxt   = idx;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nxt  = sel + SEL_W'(1);
          pre_nxt  = hit_max && !done && req[sel];
          hold_nxt = '0;
          if (en && any) begin
            sel_nxt   = idx;
            valid_nxt = 1'b1;
          end else begin
            valid_nxt = 1'b0;
          end
        end else begin
          hold_nxt = hold + HW'(1);
        end
      end
      default: valid_nxt = 1'b0;
    endcase
    gnt_nxt = valid_nxt ? (N'(1) << sel_nxt) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold      <= '0;
      sel       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold      <= hold_nxt;
      sel       <= sel_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= valid_nxt;
      preempt   <= pre_nxt;
    end
  end

endmodule
